// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 5;

    localparam int unsigned REG_ZERO    = 0;
    localparam int unsigned REG_T0      = 8;
    localparam int unsigned REG_S1      = 17;
    localparam int unsigned REG_S2      = 18;

    // Upper bounds for the generic field extractor below
    localparam int unsigned VEC_MAX_W   = 256;
    localparam int unsigned FIELD_MAX_W = 64;

    // Returns field k of width w from a packed vector, zero-extended
    function automatic logic [FIELD_MAX_W-1:0] field_get(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          k,
        input int unsigned          w
    );
        logic [VEC_MAX_W-1:0] mask;
        mask = (VEC_MAX_W'(1) << w) - VEC_MAX_W'(1);
        return FIELD_MAX_W'((vec >> (k * w)) & mask);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage mux, zero-register masking and,
// when REGFILE_BYPASS_EN is defined, write-to-read bypass.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                                  reset,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
    input  logic [ADDR_W-1:0]                     rd_addr,
`ifdef REGFILE_BYPASS_EN
    input  logic                                  we0,
    input  logic [ADDR_W-1:0]                     wa0,
    input  logic [DATA_W-1:0]                     wd0,
    input  logic                                  we1,
    input  logic [ADDR_W-1:0]                     wa1,
    input  logic [DATA_W-1:0]                     wd1,
`endif
    output logic [DATA_W-1:0]                     rd_data_c
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    always_comb begin
        rd_data_c = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
        // Port 1 checked last so it wins when both writes target this register
        if (we0 && (wa0 == rd_addr)) rd_data_c = wd0;
        if (we1 && (wa1 == rd_addr)) rd_data_c = wd1;
`endif
        if (!reset || ((ZERO_REG != 0) && (rd_addr == ZERO_ADDR))) rd_data_c = '0;
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Parametrised register file: NUM_RD read ports, two write ports (port 1 wins).
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module mips_regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic                       wr_collide
);

    localparam int unsigned       DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                         wr_collide_q, wr_collide_d;
    logic                         wen0_c, wen1_c;

    // Next-state for storage and the collision flag; port 1 applied last
    always_comb begin
        regs_d       = regs_q;
        wen0_c       = we0 && !((ZERO_REG != 0) && (wa0 == ZERO_ADDR));
        wen1_c       = we1 && !((ZERO_REG != 0) && (wa1 == ZERO_ADDR));
        wr_collide_d = wen0_c && wen1_c && (wa0 == wa1);
        if (wen0_c) regs_d[wa0] = wd0;
        if (wen1_c) regs_d[wa1] = wd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs_q       <= '0;
            wr_collide_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            wr_collide_q <= wr_collide_d;
        end
    end

    assign wr_collide = wr_collide_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .reset     (reset),
            .regs      (regs_q),
            .rd_addr   (ADDR_W'(field_get(VEC_MAX_W'(rd_addr), k, ADDR_W))),
`ifdef REGFILE_BYPASS_EN
            .we0       (we0),
            .wa0       (wa0),
            .wd0       (wd0),
            .we1       (we1),
            .wa1       (wa1),
            .wd1       (wd1),
`endif
            .rd_data_c (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/mips_regfile_mp.md
# mips_regfile_mp

Parametrised multi-port register file for the single-cycle MIPS datapath. It replaces the fixed 32×32, two-read/one-write register file. Width, depth and read-port count are configurable, and it adds a second write port with defined collision priority, a hardwired zero register, and an optional write-to-read bypass. It sits between instruction decode (register numbers) and the ALU / data-memory writeback paths.

## Interface
- DATA_W, 32, bits per register
- ADDR_W, 5, register-number width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary storage
- clock  in  1  clock; all writes on rising edge
- reset  in  1  reset, asynchronous, active-low
- we0  in  1  write enable, port 0 (ALU writeback)
- wa0  in  ADDR_W  write register number, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (load writeback)
- wa1  in  ADDR_W  write register number, port 1
- wd1  in  DATA_W  write data, port 1
- rd_addr  in  NUM_RD*ADDR_W  packed read register numbers; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
- wr_collide  out  1  registered flag: previous edge had we0 & we1 to the same address

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, each a flop updated only on a clock rising edge.
- Writes: on each rising edge, for each port with weN=1, reg[waN] <= wdN.
- Collision: we0 & we1 with wa0==wa1 stores wd1. Port 1 wins, because the load result is architecturally later.
- Collision flag: in that case wr_collide=1 for the following cycle. Otherwise it is 0.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped, and a collision at address 0 does not set wr_collide.
  - Reads of address 0 return 0 regardless of bypass.
- Reads: combinational. rd_data[k] = reg[rd_addr[k]], subject to bypass (see Configuration). All NUM_RD ports are independent and may name the same register.
- Reset (reset=0): all registers and wr_collide clear to 0 immediately, without waiting for a clock edge.
  - While reset=0, writes are ignored and every rd_data reads 0.
  - Reset asserted mid-write discards that write.
- Arithmetic: none; data passes unmodified. Out-of-range addresses are impossible because depth is exactly 2**ADDR_W.

## Timing
- Write latency: the written value is visible on rd_data after the rising edge (same cycle with bypass; see Configuration).
- Read latency: 0 cycles, combinational from rd_addr and register state.
- wr_collide: asserted exactly 1 cycle after the colliding edge; deasserts on the next edge unless the collision repeats.
- First edge after reset deassertion performs a normal write if weN=1.
- Reset values: rd_data = 0 on every port, wr_collide = 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches an enabled write address in the same cycle returns the pending write data combinationally.
  - If both ports match, the value is wd1.
  - This makes write-then-read in one single-cycle instruction pair return the new value.
- Not defined:
  - Reads return stored contents only; the pending write is seen after the edge.
  - No comparator logic is generated.

## Structure
- Package regfile_pkg:
  - default DATA_W/ADDR_W constants;
  - register-number constants REG_ZERO=0, REG_T0=8, REG_S1=17, REG_S2=18;
  - a function extracting field k from a packed vector.
- Sub-module regfile_rd_port: one read mux plus zero-register masking plus optional bypass compare. Instantiated NUM_RD times via generate.

## Test plan
- Reset while registers hold nonzero data: drive reset=0 mid-cycle → all rd_data=0 and wr_collide=0 at once. After release, reading r17 returns 0.
- Basic write/read: we0=1, wa0=17, wd0=0x0000_0005; next cycle rd_addr port0=17 → rd_data port0 = 0x0000_0005. Port1 reading r18 still returns 0.
- Zero register (ZERO_REG=1): we0=1, wa0=0, wd0=0xFFFF_FFFF → reading r0 returns 0. With ZERO_REG=0 it returns 0xFFFF_FFFF.
- Collision: we0=we1=1, wa0=wa1=8, wd0=0x11, wd1=0x22 → r8=0x22 after the edge, and wr_collide=1 for exactly one cycle.
- Bypass: write r8=0x0000_000C while reading r8 in the same cycle.
  - With REGFILE_BYPASS_EN: rd_data=0x0000_000C before the edge.
  - Without it: the old value before the edge, 0x0000_000C after.
- NUM_RD=4, all ports reading r17, r18, r8, r0 after writes of 3, 4 and 7 → 3, 4, 7, 0 simultaneously.
